traffic_state_ctrl: RTL and testbench

//   Holds the traffic-light state register that the next-state decoder drives and reads back
//   (c_state out, n_state in), and advances it once per 1 s tick from an internal prescaler.

---
 rtl/traffic_state_ctrl.sv | 175 +++++++++++++++++
 tb/tb_traffic_state_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_state_ctrl.sv
// traffic_state_ctrl
//   Holds the traffic-light state register for a 48 s signal cycle and
//   advances it once per 1 s tick from an internal prescaler. The next
//   state comes from an external decoder that reads c_state back. On every
//   load edge the loaded state is also decoded into registered lamp drives
//   and a two-digit BCD countdown, so those outputs always match c_state.
//
//   Phase table (c_state range | meaning):
//     0..19  | NS green,  EW red,    20 s
//     20..23 | NS yellow, EW red,     4 s
//     24..43 | NS red,    EW green,  20 s
//     44..47 | NS red,    EW yellow,  4 s
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   hold      in   1  freeze prescaler, state and outputs
//   n_state   in   6  next state from the external decoder
//   c_state   out  6  registered current state, 0..47
//   tick      out  1  one-cycle pulse, high on the edge that loads c_state
//   ns_light  out  3  {R,Y,G} north-south lamps, one-hot
//   ew_light  out  3  {R,Y,G} east-west lamps, one-hot
//   cnt_tens  out  4  BCD tens digit of seconds remaining in the phase
//   cnt_ones  out  4  BCD ones digit of seconds remaining in the phase

module traffic_state_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [5:0] n_state,
  output logic [5:0] c_state,
  output logic       tick,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [5:0] LAST_STATE = 6'd47;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [1:0] {
    PH_NS_GREEN  = 2'd0,
    PH_NS_YELLOW = 2'd1,
    PH_EW_GREEN  = 2'd2,
    PH_EW_YELLOW = 2'd3
  } phase_t;

  logic [PW-1:0] presc_q, presc_d;
  logic          load;
  logic [5:0]    state_d;
  logic          tick_d;
  logic [2:0]    ns_d, ew_d;
  logic [3:0]    tens_d, ones_d;

  phase_t        phase;
  logic [5:0]    load_state;
  logic [5:0]    remaining;

  // Load is gated by hold so a held wrap cycle is simply skipped and the
  // frozen count resumes where it stopped on release.
  always_comb begin
    load    = 1'b0;
    presc_d = presc_q;
    if (!hold) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        load    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // An out-of-range next state from the decoder restarts the cycle rather
  // than leaving the controller in an undecodable state.
  always_comb begin
    load_state = (n_state > LAST_STATE) ? 6'd0 : n_state;
  end

  // Decode the value being loaded, not the current register, so lamps and
  // countdown land on the same edge as c_state.
  always_comb begin
    phase     = PH_NS_GREEN;
    remaining = 6'd20;
    if (load_state < 6'd20) begin
      phase     = PH_NS_GREEN;
      remaining = 6'd20 - load_state;
    end else if (load_state < 6'd24) begin
      phase     = PH_NS_YELLOW;
      remaining = 6'd24 - load_state;
    end else if (load_state < 6'd44) begin
      phase     = PH_EW_GREEN;
      remaining = 6'd44 - load_state;
    end else begin
      phase     = PH_EW_YELLOW;
      remaining = 6'd48 - load_state;
    end
  end

  always_comb begin
    state_d = c_state;
    tick_d  = 1'b0;
    ns_d    = ns_light;
    ew_d    = ew_light;
    tens_d  = cnt_tens;
    ones_d  = cnt_ones;
    if (load) begin
      state_d = load_state;
      tick_d  = 1'b1;
      unique case (phase)
        PH_NS_GREEN: begin
          ns_d = LAMP_G;
          ew_d = LAMP_R;
        end
        PH_NS_YELLOW: begin
          ns_d = LAMP_Y;
          ew_d = LAMP_R;
        end
        PH_EW_GREEN: begin
          ns_d = LAMP_R;
          ew_d = LAMP_G;
        end
        PH_EW_YELLOW: begin
          ns_d = LAMP_R;
          ew_d = LAMP_Y;
        end
        default: begin
          ns_d = LAMP_R;
          ew_d = LAMP_R;
        end
      endcase
      // remaining is 1..20, so two compares give the BCD split.
      if (remaining >= 6'd20) begin
        tens_d = 4'd2;
        ones_d = 4'(remaining - 6'd20);
      end else if (remaining >= 6'd10) begin
        tens_d = 4'd1;
        ones_d = 4'(remaining - 6'd10);
      end else begin
        tens_d = 4'd0;
        ones_d = 4'(remaining);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      c_state  <= 6'd0;
      tick     <= 1'b0;
      ns_light <= LAMP_G;
      ew_light <= LAMP_R;
      cnt_tens <= 4'd2;
      cnt_ones <= 4'd0;
    end else begin
      presc_q  <= presc_d;
      c_state  <= state_d;
      tick     <= tick_d;
      ns_light <= ns_d;
      ew_light <= ew_d;
      cnt_tens <= tens_d;
      cnt_ones <= ones_d;
    end
  end

endmodule

// File: tb/tb_traffic_state_ctrl.sv
module tb_traffic_state_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic       force_bad = 1'b0;
  logic [5:0] n_state;
  logic [5:0] c_state;
  logic       tick;
  logic [2:0] ns_light, ew_light;
  logic [3:0] cnt_tens, cnt_ones;

  int checks = 0;
  int errors = 0;

  // Reference model: seconds-in-cycle and prescaler position as plain ints.
  int m_state = 0;
  int m_div   = 0;
  int m_tick  = 0;

  traffic_state_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .n_state  (n_state),
    .c_state  (c_state),
    .tick     (tick),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .cnt_tens (cnt_tens),
    .cnt_ones (cnt_ones)
  );

  // State decoder: increments modulo 48, or injects an illegal value.
  assign n_state = force_bad ? 6'd55 : ((c_state == 6'd47) ? 6'd0 : c_state + 6'd1);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void exp_out(input int s, output int ns, output int ew, output int rem);
    if (s < 20)      begin ns = 1; ew = 4; rem = 20 - s; end
    else if (s < 24) begin ns = 2; ew = 4; rem = 24 - s; end
    else if (s < 44) begin ns = 4; ew = 1; rem = 44 - s; end
    else             begin ns = 4; ew = 2; rem = 48 - s; end
  endfunction

  task automatic check_all(input string tag);
    int ns, ew, rem;
    exp_out(m_state, ns, ew, rem);
    chk({tag, "_state"}, 32'(c_state), 32'(m_state));
    chk({tag, "_tick"},  32'(tick),    32'(m_tick));
    chk({tag, "_ns"},    32'(ns_light), 32'(ns));
    chk({tag, "_ew"},    32'(ew_light), 32'(ew));
    chk({tag, "_tens"},  32'(cnt_tens), 32'(rem / 10));
    chk({tag, "_ones"},  32'(cnt_ones), 32'(rem % 10));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_div   = 0;
    m_tick  = 0;
  endtask

  // One clock: advance the model with the inputs in force at the edge, then compare.
  task automatic cycle(input string tag);
    @(posedge clk);
    m_tick = 0;
    if (!hold) begin
      if (m_div == TICK_DIV - 1) begin
        m_div   = 0;
        m_tick  = 1;
        m_state = force_bad ? 0 : (m_state + 1) % 48;
      end else begin
        m_div++;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic run_until_state(input int target, input string tag);
    int n = 0;
    while (m_state != target && n < 1000) begin
      cycle(tag);
      n++;
    end
    chk({tag, "_reach"}, 32'(m_state == target), 32'd1);
  endtask

  task automatic run_until_tick(input string tag);
    int n = 0;
    do begin
      cycle(tag);
      n++;
    end while (m_tick == 0 && n < 20);
    chk({tag, "_tickseen"}, 32'(tick), 32'd1);
  endtask

  task automatic run_until_wrap_cycle(input string tag);
    int n = 0;
    while (m_div != TICK_DIV - 1 && n < 20) begin
      cycle(tag);
      n++;
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_state", 32'(c_state), 32'd0);
    chk("rst_tick",  32'(tick),    32'd0);
    chk("rst_ns",    32'(ns_light), 32'd1);
    chk("rst_ew",    32'(ew_light), 32'd4);
    chk("rst_tens",  32'(cnt_tens), 32'd2);
    chk("rst_ones",  32'(cnt_ones), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // 1: first tick on the 4th edge
    for (int i = 0; i < 3; i++) cycle("t1_pre");
    chk("t1_notick", 32'(tick), 32'd0);
    cycle("t1");
    chk("t1_tick",  32'(tick),    32'd1);
    chk("t1_state", 32'(c_state), 32'd1);
    chk("t1_cnt",   32'({cnt_tens, cnt_ones}), 32'h19);

    // 2: NS green -> yellow
    run_until_state(19, "t2_run");
    run_until_tick("t2");
    chk("t2_state", 32'(c_state), 32'd20);
    chk("t2_ns",    32'(ns_light), 32'd2);
    chk("t2_cnt",   32'({cnt_tens, cnt_ones}), 32'h04);

    // 3: end of cycle and wrap
    run_until_state(47, "t3_run");
    chk("t3_ew47",  32'(ew_light), 32'd2);
    chk("t3_cnt47", 32'({cnt_tens, cnt_ones}), 32'h01);
    run_until_tick("t3");
    chk("t3_state", 32'(c_state), 32'd0);
    chk("t3_cnt",   32'({cnt_tens, cnt_ones}), 32'h20);

    // 4: hold across the wrap cycle
    run_until_state(10, "t4_run");
    run_until_wrap_cycle("t4_pre");
    hold = 1'b1;
    for (int i = 0; i < 10; i++) cycle("t4_hold");
    chk("t4_frozen", 32'(c_state), 32'd10);
    hold = 1'b0;
    cycle("t4_rel");
    chk("t4_reltick", 32'(tick), 32'd1);
    chk("t4_state",   32'(c_state), 32'd11);

    // 5: illegal next state
    run_until_state(30, "t5_run");
    run_until_wrap_cycle("t5_pre");
    force_bad = 1'b1;
    cycle("t5");
    force_bad = 1'b0;
    chk("t5_state", 32'(c_state), 32'd0);
    chk("t5_ns",    32'(ns_light), 32'd1);
    chk("t5_ew",    32'(ew_light), 32'd4);
    chk("t5_cnt",   32'({cnt_tens, cnt_ones}), 32'h20);

    // 6: asynchronous reset mid-second at state 30
    run_until_state(30, "t6_run");
    cycle("t6_mid");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_async_state", 32'(c_state), 32'd0);
    chk("t6_async_ns",    32'(ns_light), 32'd1);
    chk("t6_async_ew",    32'(ew_light), 32'd4);
    chk("t6_async_cnt",   32'({cnt_tens, cnt_ones}), 32'h20);
    @(posedge clk); @(posedge clk); #1;
    check_all("t6_inrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t6_pre");
    cycle("t6");
    chk("t6_tick",  32'(tick),    32'd1);
    chk("t6_state", 32'(c_state), 32'd1);

    // Random hold / illegal-state stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      hold      = ($urandom_range(0, 5) == 0);
      force_bad = ($urandom_range(0, 60) == 0);
      cycle("rnd");
    end
    hold = 1'b0;
    force_bad = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
